// File: rtl/sw_led_toggle.sv
// Four-channel push-button front end.
// Each button is synchronised and debounced. A debounced release toggles
// that channel's LED and emits a one-cycle event carrying the channel
// index. When several channels release together, the lowest index wins
// the event.
module sw_led_toggle #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic       EVT_VALID,
    output logic [1:0] EVT_ID
);

    // A single-cycle debounce still needs a 1-bit counter to exist.
    localparam int unsigned CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sw_raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       stable_next;
    logic [3:0]       release_now;
    logic [3:0]       led;
    logic [CNT_W-1:0] cnt      [4];
    logic [CNT_W-1:0] cnt_next [4];
    logic             evt_valid;
    logic [1:0]       evt_id;
    logic [1:0]       evt_id_next;

    assign sw_raw = {SW4, SW3, SW2, SW1};

    // Per-channel debounce: count consecutive disagreeing cycles, and adopt
    // the new level once the count reaches its limit.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = cnt[i];
            if (sync2[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                stable_next[i] = sync2[i];
                cnt_next[i]    = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Release detection, and a lowest-index-first choice of the event ID.
    always_comb begin
        release_now = stable & ~stable_next;
        evt_id_next = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (release_now[i]) begin
                evt_id_next = 2'(i);
            end
        end
    end

    // State registers. LEDs and the event outputs are registered, so there
    // is no combinational path from the switches to the outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            led       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= sw_raw;
            sync2     <= sync1;
            stable    <= stable_next;
            led       <= led ^ release_now;
            evt_valid <= |release_now;
            evt_id    <= evt_id_next;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign LED1      = led[0];
    assign LED2      = led[1];
    assign LED3      = led[2];
    assign LED4      = led[3];
    assign EVT_VALID = evt_valid;
    assign EVT_ID    = evt_id;

endmodule

// File: tb/tb_sw_led_toggle.sv
// Bench for sw_led_toggle with DEBOUNCE_CYCLES = 4. It runs a vector table,
// directed scenarios and a randomised soak. Every cycle is compared against
// a window-based reference model.
module tb_sw_led_toggle;

    localparam int unsigned D = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] sw;
    logic       LED1, LED2, LED3, LED4;
    logic       EVT_VALID;
    logic [1:0] EVT_ID;

    always #5 CLK = ~CLK;

    sw_led_toggle #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW1      (sw[0]),
        .SW2      (sw[1]),
        .SW3      (sw[2]),
        .SW4      (sw[3]),
        .LED1     (LED1),
        .LED2     (LED2),
        .LED3     (LED3),
        .LED4     (LED4),
        .EVT_VALID(EVT_VALID),
        .EVT_ID   (EVT_ID)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model. m_raw holds the raw samples seen at recent edges.
    // At any edge, the value acted on is the one sampled two edges earlier.
    // A channel's stable level flips once its last D acted-on values all
    // disagree with that level.
    logic [3:0] m_raw [$];
    logic [3:0] m_stable;
    logic [3:0] m_led;
    logic       m_valid;
    logic [1:0] m_id;

    // Event bookkeeping for the directed scenarios.
    int         ev_cnt;
    logic [1:0] last_id;
    logic [3:0] ev_diff;
    logic [3:0] led_prev;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [3:0] led;
        logic       valid;
        logic [1:0] id;
    } vec_t;

    vec_t tbl [30];

    function automatic logic [3:0] leds();
        return {LED4, LED3, LED2, LED1};
    endfunction

    task automatic model_reset();
        m_raw.delete();
        m_raw.push_back(4'b0);
        m_raw.push_back(4'b0);
        m_stable = '0;
        m_led    = '0;
        m_valid  = 1'b0;
        m_id     = 2'd0;
    endtask

    task automatic model_edge(input logic [3:0] s);
        logic [3:0] nxt;
        logic [3:0] rel;
        logic [3:0] tmp;
        logic       all;
        m_raw.push_back(s);
        if (m_raw.size() > D + 2) void'(m_raw.pop_front());
        nxt = m_stable;
        if (m_raw.size() == D + 2) begin
            for (int ch = 0; ch < 4; ch++) begin
                all = 1'b1;
                for (int j = 0; j < int'(D); j++) begin
                    tmp = m_raw[j];
                    if (tmp[ch] == m_stable[ch]) all = 1'b0;
                end
                if (all) nxt[ch] = ~m_stable[ch];
            end
        end
        rel      = m_stable & ~nxt;
        m_led    = m_led ^ rel;
        m_valid  = |rel;
        m_id     = 2'd0;
        for (int ch = 3; ch >= 0; ch--) begin
            if (rel[ch]) m_id = 2'(ch);
        end
        m_stable = nxt;
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock: drive after the falling edge, update the model at the
    // rising edge, and compare on the next falling edge.
    task automatic step(input logic r, input logic [3:0] s);
        RST = r;
        sw  = s;
        @(posedge CLK);
        if (r) model_reset();
        else   model_edge(s);
        @(negedge CLK);
        vectors++;
        if (leds() !== m_led || EVT_VALID !== m_valid || (m_valid && EVT_ID !== m_id)) begin
            miscompares++;
            $display("FAIL model t=%0t: got led=%b v=%b id=%0d, expected led=%b v=%b id=%0d",
                     $time, leds(), EVT_VALID, EVT_ID, m_led, m_valid, m_id);
        end
        if (EVT_VALID === 1'b1) begin
            ev_cnt++;
            last_id = EVT_ID;
            ev_diff = leds() ^ led_prev;
        end
        led_prev = leds();
    endtask

    task automatic clear_events();
        ev_cnt  = 0;
        last_id = 2'd0;
        ev_diff = '0;
    endtask

    logic [3:0] cur;

    initial begin
        RST = 1'b1;
        sw  = '0;
        model_reset();
        led_prev = '0;
        clear_events();

        // Reset state.
        #2;
        chk("reset_led", int'(leds()), 0);
        chk("reset_evt_valid", int'(EVT_VALID), 0);
        chk("reset_evt_id", int'(EVT_ID), 0);
        @(negedge CLK);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);

        // Scenario 1: clean press on SW1 for 20 cycles. The release is
        // sampled at step 20, so LED1 toggles and the event fires at step 25.
        for (int i = 0; i < 30; i++) begin
            tbl[i].rst   = 1'b0;
            tbl[i].sw    = (i < 20) ? 4'b0001 : 4'b0000;
            tbl[i].led   = (i >= 25) ? 4'b0001 : 4'b0000;
            tbl[i].valid = (i == 25);
            tbl[i].id    = 2'd0;
        end
        for (int i = 0; i < 30; i++) begin
            step(tbl[i].rst, tbl[i].sw);
            vectors++;
            if (leds() !== tbl[i].led || EVT_VALID !== tbl[i].valid ||
                (tbl[i].valid && EVT_ID !== tbl[i].id)) begin
                miscompares++;
                $display("FAIL table[%0d]: got led=%b v=%b id=%0d, expected led=%b v=%b id=%0d",
                         i, leds(), EVT_VALID, EVT_ID, tbl[i].led, tbl[i].valid, tbl[i].id);
            end
        end

        // Scenario 2: SW2 bounces every 2 cycles, then holds, then releases.
        clear_events();
        for (int i = 0; i < 16; i++) step(1'b0, ((i % 4) < 2) ? 4'b0010 : 4'b0000);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0010);
        chk("bounce_no_event_before_release", ev_cnt, 0);
        chk("bounce_led2_unchanged_by_press", int'(LED2), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);
        chk("bounce_event_count", ev_cnt, 1);
        chk("bounce_event_id", int'(last_id), 1);
        chk("bounce_led2", int'(LED2), 1);

        // Scenario 3: two clean press/release cycles on SW3.
        clear_events();
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0100);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);
        chk("double_led3_first", int'(LED3), 1);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0100);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);
        chk("double_led3_second", int'(LED3), 0);
        chk("double_event_count", ev_cnt, 2);
        chk("double_event_id", int'(last_id), 2);

        // Scenario 4: SW2 and SW4 are released together.
        clear_events();
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1010);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);
        chk("simul_event_count", ev_cnt, 1);
        chk("simul_event_id", int'(last_id), 1);
        chk("simul_same_edge_toggle", int'(ev_diff), 4'b1010);
        chk("simul_leds", int'(leds()), 4'b1001);

        // Scenario 5: reset arrives while SW1 is held and CNT1 = 2, with
        // LED1 and LED4 lit.
        clear_events();
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0001);
        #2 RST = 1'b1;
        #1;
        chk("async_reset_led", int'(leds()), 0);
        chk("async_reset_evt_valid", int'(EVT_VALID), 0);
        @(negedge CLK);
        step(1'b1, 4'b0001);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0001);
        chk("reset_held_no_led", int'(LED1), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);
        chk("reset_redebounced_led1", int'(LED1), 1);
        chk("reset_event_count", ev_cnt, 1);
        chk("reset_event_id", int'(last_id), 0);

        // Scenario 6: a 3-cycle glitch on SW4 is shorter than the debounce.
        clear_events();
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1000);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);
        chk("glitch_no_event", ev_cnt, 0);
        chk("glitch_led4", int'(LED4), 0);

        // Randomised soak: bouncy levels with occasional resets.
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
            end
            step(($urandom_range(0, 399) == 0), cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_led_toggle.md
SW_LED_TOGGLE -- requirements
Module: sw_led_toggle

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, SHALL set the consecutive cycles a changed input must persist (10 ms at 25 MHz); legal range 1..2^20.
REQ-003 CLK  input  1  system clock, 25 MHz on board.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 SW1..SW4  input  1 each  raw push-button levels, asynchronous to CLK, 1 = pressed.
REQ-006 LED1..LED4  output  1 each  toggle-latched LED drive, 1 = lit.
REQ-007 EVT_VALID  output  1  single-cycle pulse marking a debounced release.
REQ-008 EVT_ID  output  2  index of the released switch (0 = SW1 .. 3 = SW4); valid only while EVT_VALID = 1.

Function
REQ-009 Each SWn SHALL pass through a two-flop synchronizer before any other logic.
REQ-010 Each channel SHALL hold a debounced level STABLEn and a counter CNTn sized ceil(log2(DEBOUNCE_CYCLES)), minimum 1 bit.
REQ-011 On any edge where sync2n equals STABLEn, CNTn SHALL clear to 0.
REQ-012 On an edge where sync2n differs from STABLEn and CNTn < DEBOUNCE_CYCLES-1, CNTn SHALL increment.
REQ-013 On an edge where sync2n differs and CNTn = DEBOUNCE_CYCLES-1, STABLEn SHALL take sync2n and CNTn SHALL clear.
REQ-014 A level change on SWn sampled at edge E and held SHALL update STABLEn at edge E+DEBOUNCE_CYCLES+1.
REQ-015 Any bounce back to the old level before that edge SHALL restart the count from 0.
REQ-016 On the edge where STABLEn goes 1->0 (release), LEDn SHALL invert.
REQ-017 A press (STABLEn 0->1) SHALL NOT change LEDn.
REQ-018 LED outputs SHALL be direct register outputs with no combinational path from SW inputs.
REQ-019 On the same edge as a release, EVT_VALID SHALL assert for exactly one cycle with EVT_ID = n.
REQ-020 On simultaneous releases, every affected LED SHALL toggle on that edge.
REQ-021 On simultaneous releases, EVT_ID SHALL report the lowest index; the other releases produce no event.
REQ-022 Channels SHALL be fully independent: counters and state never interact except through EVT_ID priority.
REQ-023 Counters SHALL never wrap; CNTn stays within 0..DEBOUNCE_CYCLES-1.

Reset
REQ-024 While RST = 1, SHALL clear: all synchronizer flops, STABLEn, CNTn, LED1..LED4, EVT_VALID, and EVT_ID (to 0).
REQ-025 RST asserted mid-count or mid-bounce SHALL discard all progress with no toggle or event.
REQ-026 A switch held across reset deassertion SHALL be seen as a new press, debounced normally; no LED change until its release.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Scenario 1, clean press: SW1 = 1 for 20 cycles, then 0. Required: LED1 stays 0 during the press; LED1 -> 1 at release edge +5; EVT_VALID = 1 for one cycle with EVT_ID = 0.
REQ-028 Scenario 2, bounce: SW2 toggles every 2 cycles for 16 cycles, then holds 1 for 10, then 0. Required: exactly one toggle of LED2 and one event (EVT_ID = 1); no activity during the bounce.
REQ-029 Scenario 3, double press: two clean SW3 press/release cycles. Required: LED3 goes 0 -> 1 -> 0; two events with EVT_ID = 2.
REQ-030 Scenario 4, simultaneous release: SW2 and SW4 released on the same cycle after a stable press. Required: LED2 and LED4 toggle on the same edge; one event with EVT_ID = 1.
REQ-031 Scenario 5, reset mid-operation: RST pulsed while SW1 is held with CNT1 = 2. Required: all outputs 0 immediately (asynchronous); after release, LED1 -> 1 only if the press re-debounced after reset.
REQ-032 Scenario 6, short glitch: a 3-cycle pulse on SW4. Required: no change on LED4 or EVT_VALID.
